router_ingress_ctrl: RTL and testbench

- Upstream stage of the three per-port output FIFOs in the 1x3 router.
- Accepts byte-serial packets from the source: a header byte, then payload bytes, then one parity byte.
- Steers each packet into the FIFO selected by the header's address field and generates write_enb and lfd_state in the timing the FIFOs require.
- Applies backpressure via busy, checks parity, and drops packets addressed to the invalid port or stuck behind a non-draining FIFO.

---
 rtl/router_pkg.sv | 10 +
 rtl/router_ingress_ctrl.sv | 87 ++++++++
 tb/tb_router_ingress_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared FSM states and header field layout for the 1x3 router.
package router_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_EMPTY, LFD, HDR, PAYLOAD, DROP} state_t;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W = 2;
  localparam int LEN_LSB = 2;
  localparam int LEN_W = 6;
  localparam int NUM_PORTS = 3;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;
endpackage

// File: rtl/router_ingress_ctrl.sv
// router_ingress_ctrl: steers byte-serial packets into one of three FIFOs,
// generating lfd_state/write_enb timing, backpressure, parity check and drops.
module router_ingress_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [7:0]           data_in,
  output logic                 busy,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  output logic [7:0]           data_out,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 lfd_state,
  output logic                 err,
  output logic                 drop
);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  state_t state, state_n;
  logic [7:0] hdr_reg, par_acc, data_q;
  logic [ADDR_W-1:0] dest, hdr_dest;
  logic [6:0] remaining;
  logic [15:0] tmo_cnt;
  logic [3:0] empty_x, full_x;
  logic [NUM_PORTS-1:0] sel;
  logic xfer;
  // Pad flags so the invalid address 3 indexes a harmless zero bit.
  assign empty_x = {1'b0, fifo_empty};
  assign full_x = {1'b0, fifo_full};
  assign hdr_dest = data_in[ADDR_LSB +: ADDR_W];
  assign sel = NUM_PORTS'(1) << dest;
  assign busy = (state == IDLE || state == DROP) ? 1'b0 : (state == PAYLOAD) ? full_x[dest] : 1'b1;
  assign xfer = in_valid & ~busy;
  assign lfd_state = state == LFD;
  assign write_enb = (state == HDR || (state == PAYLOAD && xfer)) ? sel : '0;
  assign data_out = (state == HDR) ? hdr_reg : (state == PAYLOAD) ? data_in : data_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (xfer) state_n = (hdr_dest == ADDR_INVALID) ? DROP : empty_x[hdr_dest] ? LFD : WAIT_EMPTY;
      WAIT_EMPTY: state_n = empty_x[dest] ? LFD : (tmo_cnt == TMO_LAST) ? DROP : WAIT_EMPTY;
      LFD:        state_n = HDR;
      HDR:        state_n = PAYLOAD;
      PAYLOAD,
      DROP:       if (xfer && remaining == 7'd1) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hdr_reg <= '0;
      par_acc <= '0;
      data_q <= '0;
      dest <= '0;
      remaining <= '0;
      tmo_cnt <= '0;
      err <= 1'b0;
      drop <= 1'b0;
    end else begin
      state <= state_n;
      data_q <= data_out;
      drop <= state_n == DROP && state != DROP;
      case (state)
        IDLE: if (xfer) begin
          hdr_reg <= data_in;
          par_acc <= data_in;
          dest <= hdr_dest;
          remaining <= 7'(data_in[LEN_LSB +: LEN_W]) + 7'd1;
          tmo_cnt <= '0;
          err <= 1'b0;
        end
        WAIT_EMPTY: tmo_cnt <= tmo_cnt + 16'd1;
        PAYLOAD: if (xfer) begin
          remaining <= remaining - 7'd1;
          if (remaining > 7'd1) par_acc <= par_acc ^ data_in;
          else err <= data_in != par_acc;
        end
        DROP: if (xfer) remaining <= remaining - 7'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_router_ingress_ctrl.sv
// tb_router_ingress_ctrl: directed-vector bench for router_ingress_ctrl.
module tb_router_ingress_ctrl;
  logic clock = 0, reset = 1, in_valid = 0, in_valid_t = 0;
  logic [7:0] data_in = 0, data_out, data_out_t;
  logic [2:0] fifo_full = 0, fifo_empty = 3'b111;
  logic [2:0] write_enb, write_enb_t;
  logic busy, lfd_state, err, drop, busy_t, lfd_t, err_t, drop_t;
  int n_chk = 0, n_pass = 0, n_lfd = 0, n_drop = 0, n_we_t = 0;
  typedef struct packed {logic [2:0] we; logic [7:0] d;} wr_t;
  wr_t log_q[$];
  always #5 clock = ~clock;
  router_ingress_ctrl dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .data_in(data_in), .busy(busy),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .data_out(data_out),
    .write_enb(write_enb), .lfd_state(lfd_state), .err(err), .drop(drop));
  router_ingress_ctrl #(.TIMEOUT(8)) dut_t (
    .clock(clock), .reset(reset), .in_valid(in_valid_t), .data_in(data_in), .busy(busy_t),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .data_out(data_out_t),
    .write_enb(write_enb_t), .lfd_state(lfd_t), .err(err_t), .drop(drop_t));
  always @(negedge clock) begin
    if (|write_enb) log_q.push_back({write_enb, data_out});
    if (lfd_state) n_lfd++;
    if (drop) n_drop++;
    if (|write_enb_t) n_we_t++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic send(input logic [7:0] b, output int waits);
    bit done = 0;
    waits = 0;
    data_in = b;
    in_valid = 1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clock);
      if (!busy) done = 1;
      else waits++;
      @(posedge clock);
      #1;
    end
    if (!done) check("send_bound", 0, 1);
  endtask
  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic chk_log(input string tag, input int base, input logic [2:0] we,
                         input logic [7:0] exp [6], input int n);
    check({tag, "_nwr"}, log_q.size() - base, n);
    for (int i = 0; i < n && base + i < log_q.size(); i++)
      check({tag, "_wr"}, log_q[base + i], {we, exp[i]});
  endtask
  initial begin
    int b, w, l0, d0, nb;
    logic [7:0] pk [6];
    bit seen;
    #1;
    check("rst_out", {busy, write_enb, lfd_state, err, drop, data_out}, 0);
    @(posedge clock);
    #1;
    reset = 0;
    // 1: clean packet to port 1
    pk = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00};
    b = log_q.size();
    l0 = n_lfd;
    send(8'h0D, w);
    check("s1_lfd", lfd_state, 1);
    send(8'h11, w);
    send(8'h22, w);
    send(8'h33, w);
    send(8'h0D, w);
    idle(3);
    chk_log("s1", b, 3'b010, pk, 5);
    check("s1_nlfd", n_lfd - l0, 1);
    check("s1_err", err, 0);
    // 2: bad parity
    pk = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF, 8'h00};
    b = log_q.size();
    send(8'h0D, w);
    send(8'h11, w);
    send(8'h22, w);
    send(8'h33, w);
    send(8'hFF, w);
    idle(2);
    chk_log("s2", b, 3'b010, pk, 5);
    check("s2_err", err, 1);
    // 3: FIFO full for two cycles before 0x22
    pk = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00};
    b = log_q.size();
    send(8'h0D, w);
    check("s3_err_clr", err, 0);
    send(8'h11, w);
    data_in = 8'h22;
    fifo_full = 3'b010;
    repeat (2) begin
      @(negedge clock);
      check("s3_busy", busy, 1);
      check("s3_we", write_enb, 0);
      @(posedge clock);
      #1;
    end
    fifo_full = 0;
    send(8'h22, w);
    send(8'h33, w);
    send(8'h0D, w);
    idle(2);
    chk_log("s3", b, 3'b010, pk, 5);
    check("s3_err", err, 0);
    // 4: invalid destination
    b = log_q.size();
    d0 = n_drop;
    send(8'h07, w);
    check("s4_drop", drop, 1);
    send(8'h55, w);
    check("s4_wait55", w, 0);
    send(8'h52, w);
    check("s4_wait52", w, 0);
    idle(2);
    check("s4_nwr", log_q.size() - b, 0);
    check("s4_ndrop", n_drop - d0, 1);
    // 5a: port 2 not empty for 10 cycles
    pk = '{8'h0A, 8'h01, 8'h02, 8'h09, 8'h00, 8'h00};
    b = log_q.size();
    fifo_empty = 3'b011;
    send(8'h0A, w);
    in_valid = 0;
    nb = 0;
    repeat (10) begin
      @(negedge clock);
      if (busy) nb++;
      @(posedge clock);
      #1;
    end
    check("s5a_busy", nb, 10);
    fifo_empty = 3'b111;
    send(8'h01, w);
    check("s5a_lat", w, 3);
    send(8'h02, w);
    send(8'h09, w);
    idle(2);
    chk_log("s5a", b, 3'b100, pk, 4);
    check("s5a_err", err, 0);
    // 5b: TIMEOUT=8 instance, port 2 stays non-empty
    fifo_empty = 3'b011;
    data_in = 8'h0A;
    in_valid_t = 1;
    @(negedge clock);
    check("s5b_hdr_busy", busy_t, 0);
    @(posedge clock);
    #1;
    in_valid_t = 0;
    nb = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (drop_t) seen = 1;
      else if (busy_t) nb++;
      @(posedge clock);
      #1;
    end
    check("s5b_drop", seen, 1);
    check("s5b_busy", nb, 8);
    for (int i = 0; i < 3; i++) begin
      data_in = 8'h30 + 8'(i);
      in_valid_t = 1;
      @(negedge clock);
      check("s5b_consume", busy_t, 0);
      @(posedge clock);
      #1;
    end
    in_valid_t = 0;
    check("s5b_nwr", n_we_t, 0);
    fifo_empty = 3'b111;
    data_in = 8'h00;
    in_valid_t = 1;
    @(posedge clock);
    #1;
    in_valid_t = 0;
    check("s5b_idle", lfd_t, 1);
    // 6: reset mid-packet, then zero-length packet
    send(8'h0D, w);
    send(8'h11, w);
    in_valid = 0;
    data_in = 8'h5A;
    reset = 1;
    #1;
    check("s6_rst_out", {busy, write_enb, lfd_state, err, drop, data_out}, 0);
    @(posedge clock);
    #1;
    reset = 0;
    pk = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    b = log_q.size();
    send(8'h00, w);
    send(8'h00, w);
    idle(3);
    chk_log("s6", b, 3'b001, pk, 2);
    check("s6_err", err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
